// File: rtl/sdff_bank_r.sv
// sdff_bank_r: WIDTH x DEPTH scan register bank with one serial chain (SI -> SO) and a scan-length counter.
// Optional macro SDFF_BANK_NOTIFIER_EN adds a NOTIFIER input whose transitions poison every stage bit with X.
module sdff_bank_r #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CK,
  input  logic             R,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             SE,
  input  logic             SI,
`ifdef SDFF_BANK_NOTIFIER_EN
  input  logic             NOTIFIER,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO,
  output logic             SCAN_DONE
);

  localparam int L  = WIDTH * DEPTH;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] L_CNT = CW'(L);

  // Flat chain: bit s*WIDTH+b is stage s, bit b; stage 0 sits at the low end.
  logic [L-1:0]  r_chain;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [L-1:0]  w_shift;
  logic [L-1:0]  w_cap;
  logic [CW-1:0] w_cnt_inc;

  always_comb begin
    w_shift    = '0;
    w_shift[0] = SI;
    for (int i = 1; i < L; i++) begin
      w_shift[i] = r_chain[i-1];
    end
    w_cap            = '0;
    w_cap[WIDTH-1:0] = D;
    for (int s = 1; s < DEPTH; s++) begin
      w_cap[s*WIDTH +: WIDTH] = r_chain[(s-1)*WIDTH +: WIDTH];
    end
    w_cnt_inc = (r_cnt == L_CNT) ? r_cnt : r_cnt + CW'(1);
  end

`ifdef SDFF_BANK_NOTIFIER_EN
  logic r_ntf_q;
  always @(posedge CK or posedge R or edge NOTIFIER) begin
`else
  always_ff @(posedge CK or posedge R) begin
`endif
    if (R) begin
      r_chain <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
`ifdef SDFF_BANK_NOTIFIER_EN
      r_ntf_q <= NOTIFIER;
    end else if (NOTIFIER !== r_ntf_q) begin
      r_ntf_q <= NOTIFIER;
      r_chain <= 'x;
      r_done  <= 1'bx;
`endif
    end else begin
      // Unknown SE/EN land in the default arms so the flops go X rather than merge.
      case (SE)
        1'b1: begin
          r_chain <= w_shift;
          r_cnt   <= w_cnt_inc;
          r_done  <= (w_cnt_inc == L_CNT);
        end
        1'b0: begin
          r_cnt  <= '0;
          r_done <= 1'b0;
          case (EN)
            1'b1: r_chain <= w_cap;
            1'b0: r_chain <= r_chain;
            default: begin
              r_chain <= 'x;
              r_cnt   <= 'x;
              r_done  <= 1'bx;
            end
          endcase
        end
        default: begin
          r_chain <= 'x;
          r_cnt   <= 'x;
          r_done  <= 1'bx;
        end
      endcase
    end
  end

  assign Q         = r_chain[(DEPTH-1)*WIDTH +: WIDTH];
  assign QN        = ~Q;
  assign SO        = r_chain[L-1];
  assign SCAN_DONE = r_done;

endmodule

// File: tb/tb_sdff_bank_r.sv
// Directed bench for sdff_bank_r at WIDTH=4, DEPTH=2 (chain length 8).
module tb_sdff_bank_r;
  logic       CK = 1'b0;
  logic       R  = 1'b0;
  logic       EN = 1'b0;
  logic [3:0] D  = 4'h0;
  logic       SE = 1'b0;
  logic       SI = 1'b0;
`ifdef SDFF_BANK_NOTIFIER_EN
  logic       NOTIFIER = 1'b0;
`endif
  logic [3:0] Q;
  logic [3:0] QN;
  logic       SO;
  logic       SCAN_DONE;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  sdff_bank_r #(.WIDTH(4), .DEPTH(2)) dut (
    .CK(CK), .R(R), .EN(EN), .D(D), .SE(SE), .SI(SI),
`ifdef SDFF_BANK_NOTIFIER_EN
    .NOTIFIER(NOTIFIER),
`endif
    .Q(Q), .QN(QN), .SO(SO), .SCAN_DONE(SCAN_DONE)
  );

  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    #2 R = 1'b1;
    #1;
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL reset_q got=%h exp=0", Q); end
    checks++; if (QN !== 4'hF) begin failures++; $display("FAIL reset_qn got=%h exp=f", QN); end
    checks++; if (SO !== 1'b0) begin failures++; $display("FAIL reset_so got=%b exp=0", SO); end
    checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", SCAN_DONE); end
    SE = 1'b1; SI = 1'b1; EN = 1'b1; D = 4'hF;
    tick(); tick();
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL reset_hold_q got=%h exp=0", Q); end
    checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL reset_hold_done got=%b exp=0", SCAN_DONE); end
    R = 1'b0; SE = 1'b0; SI = 1'b0; EN = 1'b0; D = 4'h0;
  endtask

  task automatic test_async_reset();
    EN = 1'b1; D = 4'hA;
    tick(); tick();
    checks++; if (Q !== 4'hA) begin failures++; $display("FAIL async_load_q got=%h exp=a", Q); end
    EN = 1'b0;
    #2 R = 1'b1;
    #1;
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL async_q got=%h exp=0", Q); end
    checks++; if (QN !== 4'hF) begin failures++; $display("FAIL async_qn got=%h exp=f", QN); end
    checks++; if (SO !== 1'b0) begin failures++; $display("FAIL async_so got=%b exp=0", SO); end
    checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL async_done got=%b exp=0", SCAN_DONE); end
    #1 R = 1'b0;
  endtask

  task automatic test_functional_pipe();
    SE = 1'b0; EN = 1'b1; D = 4'hA;
    tick();
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL pipe_e1_q got=%h exp=0", Q); end
    D = 4'h5;
    tick();
    checks++; if (Q !== 4'hA) begin failures++; $display("FAIL pipe_e2_q got=%h exp=a", Q); end
    checks++; if (SO !== 1'b1) begin failures++; $display("FAIL pipe_e2_so got=%b exp=1", SO); end
    tick();
    checks++; if (Q !== 4'h5) begin failures++; $display("FAIL pipe_e3_q got=%h exp=5", Q); end
    EN = 1'b0; D = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (Q !== 4'h5) begin failures++; $display("FAIL pipe_hold_q%0d got=%h exp=5", k, Q); end
      checks++; if (QN !== 4'hA) begin failures++; $display("FAIL pipe_hold_qn%0d got=%h exp=a", k, QN); end
    end
  endtask

  task automatic test_scan_load();
    logic [0:7] si_seq;
    si_seq = 8'b10110010;
    SE = 1'b1; EN = 1'b0;
    for (int k = 0; k < 8; k++) begin
      SI = si_seq[k];
      tick();
      if (k == 6) begin
        checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL scan_done_e7 got=%b exp=0", SCAN_DONE); end
      end
    end
    checks++; if (SCAN_DONE !== 1'b1) begin failures++; $display("FAIL scan_done_e8 got=%b exp=1", SCAN_DONE); end
    checks++; if (Q !== 4'hB) begin failures++; $display("FAIL scan_q got=%h exp=b", Q); end
    checks++; if (SO !== 1'b1) begin failures++; $display("FAIL scan_so got=%b exp=1", SO); end
    SE = 1'b0; EN = 1'b1; D = 4'h6; SI = 1'b0;
    tick();
    checks++; if (Q !== 4'h2) begin failures++; $display("FAIL scan_stage0 got=%h exp=2", Q); end
    checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL scan_done_drop got=%b exp=0", SCAN_DONE); end
    EN = 1'b0;
  endtask

  task automatic test_priority_saturation();
    logic [0:9] so_seq;
    logic exp_so;
    so_seq = 10'b0100110000;
    for (int k = 0; k < 10; k++) exp_q.push_back(so_seq[k]);
    SE = 1'b1; EN = 1'b1; D = 4'hF; SI = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_so = exp_q.pop_front();
      checks++; if (SO !== exp_so) begin failures++; $display("FAIL prio_so_e%0d got=%b exp=%b", k, SO, exp_so); end
      if (k == 4) begin
        checks++; if (Q !== 4'h6) begin failures++; $display("FAIL prio_q_e4 got=%h exp=6", Q); end
      end
      if (k == 7) begin
        checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL prio_done_e7 got=%b exp=0", SCAN_DONE); end
      end
      if (k >= 8) begin
        checks++; if (SCAN_DONE !== 1'b1) begin failures++; $display("FAIL prio_done_e%0d got=%b exp=1", k, SCAN_DONE); end
      end
    end
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL prio_q_end got=%h exp=0", Q); end
    SE = 1'b0; EN = 1'b0;
    tick();
    checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL prio_done_clear got=%b exp=0", SCAN_DONE); end
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL prio_hold_q got=%h exp=0", Q); end
  endtask

  task automatic test_reset_mid_scan();
    SE = 1'b1; SI = 1'b1; EN = 1'b0;
    tick(); tick(); tick();
    checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL mid_done_pre got=%b exp=0", SCAN_DONE); end
    #2 R = 1'b1;
    #1;
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL mid_reset_q got=%h exp=0", Q); end
    #1 R = 1'b0;
    SI = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (SO !== 1'b0) begin failures++; $display("FAIL mid_so_e%0d got=%b exp=0", k, SO); end
      if (k == 5 || k == 7) begin
        checks++; if (SCAN_DONE !== 1'b0) begin failures++; $display("FAIL mid_done_e%0d got=%b exp=0", k, SCAN_DONE); end
      end
    end
    checks++; if (SCAN_DONE !== 1'b1) begin failures++; $display("FAIL mid_done_e8 got=%b exp=1", SCAN_DONE); end
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL mid_q_end got=%h exp=0", Q); end
    SE = 1'b0;
    tick();
  endtask

`ifdef SDFF_BANK_NOTIFIER_EN
  task automatic test_notifier();
    #2 NOTIFIER = 1'b1;
    #1;
    checks++; if (Q !== 4'bxxxx) begin failures++; $display("FAIL ntf_q got=%b exp=xxxx", Q); end
    checks++; if (SO !== 1'bx) begin failures++; $display("FAIL ntf_so got=%b exp=x", SO); end
    checks++; if (SCAN_DONE !== 1'bx) begin failures++; $display("FAIL ntf_done got=%b exp=x", SCAN_DONE); end
    R = 1'b1;
    #1;
    checks++; if (Q !== 4'h0) begin failures++; $display("FAIL ntf_reset_q got=%h exp=0", Q); end
    #1 R = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_async_reset();
    test_functional_pipe();
    test_scan_load();
    test_priority_saturation();
    test_reset_mid_scan();
`ifdef SDFF_BANK_NOTIFIER_EN
    test_notifier();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
